mem_bus_arbiter: RTL and testbench

Shares one memory port between the MIPS instruction-fetch requester (read-only) and the data requester (read/write). Each transaction is decoded against the ROM window (base 0x00400000) and the RAM window (base 0x10010000) and converted to a word index. The block then sequences a fixed-latency access and returns the read data or an error flag to the granted requester. It sits between the core's fetch/load-store units and the ROM/RAM arrays.

---
 rtl/mem_bus_arbiter.sv | 156 +++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one ROM/RAM port between instruction fetch and data access.
// Latency: MEM_LATENCY+1 cycles to Done on a hit, 1 cycle on a decode error; requests wait (level-held) while busy.
module mem_bus_arbiter #(
    parameter int BIT_WIDTH   = 32,
    parameter int ROM_DEPTH   = 1024,
    parameter int RAM_DEPTH   = 1024,
    parameter int MEM_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 I_Req_in,
    input  logic [BIT_WIDTH-1:0] I_Address_in,
    output logic [BIT_WIDTH-1:0] I_Read_Data_out,
    output logic                 I_Done_out,
    output logic                 I_Err_out,
    input  logic                 D_Req_in,
    input  logic                 D_Write_in,
    input  logic [BIT_WIDTH-1:0] D_Address_in,
    input  logic [BIT_WIDTH-1:0] D_Write_Data_in,
    output logic [BIT_WIDTH-1:0] D_Read_Data_out,
    output logic                 D_Done_out,
    output logic                 D_Err_out,
    output logic                 Mem_En_out,
    output logic                 Mem_Sel_RAM_out,
    output logic                 Mem_We_out,
    output logic [BIT_WIDTH-1:0] Mem_Address_out,
    output logic [BIT_WIDTH-1:0] Mem_Write_Data_out,
    input  logic [BIT_WIDTH-1:0] Mem_Read_Data_in
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

    localparam logic [BIT_WIDTH-1:0] ROM_BASE = BIT_WIDTH'(32'h0040_0000);
    localparam logic [BIT_WIDTH-1:0] RAM_BASE = BIT_WIDTH'(32'h1001_0000);
    localparam logic [BIT_WIDTH-1:0] ROM_SPAN = BIT_WIDTH'(4 * ROM_DEPTH);
    localparam logic [BIT_WIDTH-1:0] RAM_SPAN = BIT_WIDTH'(4 * RAM_DEPTH);

    logic [1:0]           state;
    logic [CNT_W-1:0]     cnt;
    logic                 last_grant_d;
    logic                 gnt_d;

    logic                 any_req;
    logic                 pick_d;
    logic [BIT_WIDTH-1:0] addr_sel;
    logic                 wr_sel;
    logic [BIT_WIDTH-1:0] rom_off;
    logic [BIT_WIDTH-1:0] ram_off;
    logic                 rom_hit;
    logic                 ram_hit;
    logic                 dec_err;
    logic [BIT_WIDTH-1:0] dec_idx;

    // Decode is done on the granted requester's live inputs; the registers
    // loaded at the grant edge then become the latched copy.
    always_comb begin
        any_req  = I_Req_in | D_Req_in;
        pick_d   = D_Req_in & (~I_Req_in | ~last_grant_d);
        addr_sel = pick_d ? D_Address_in : I_Address_in;
        wr_sel   = pick_d & D_Write_in;
        rom_off  = addr_sel - ROM_BASE;
        ram_off  = addr_sel - RAM_BASE;
        rom_hit  = (addr_sel >= ROM_BASE) && (rom_off < ROM_SPAN);
        ram_hit  = (addr_sel >= RAM_BASE) && (ram_off < RAM_SPAN);
        dec_err  = (addr_sel[1:0] != 2'b00)
                 | ~(rom_hit | ram_hit)
                 | (wr_sel & rom_hit)
                 | (~pick_d & ram_hit);
        dec_idx  = rom_hit ? (rom_off >> 2) : (ram_off >> 2);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state              <= ST_IDLE;
            cnt                <= '0;
            last_grant_d       <= 1'b1;
            gnt_d              <= 1'b0;
            I_Read_Data_out    <= '0;
            I_Done_out         <= 1'b0;
            I_Err_out          <= 1'b0;
            D_Read_Data_out    <= '0;
            D_Done_out         <= 1'b0;
            D_Err_out          <= 1'b0;
            Mem_En_out         <= 1'b0;
            Mem_Sel_RAM_out    <= 1'b0;
            Mem_We_out         <= 1'b0;
            Mem_Address_out    <= '0;
            Mem_Write_Data_out <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        last_grant_d <= pick_d;
                        gnt_d        <= pick_d;
                        if (dec_err) begin
                            state      <= ST_DONE;
                            I_Done_out <= ~pick_d;
                            I_Err_out  <= ~pick_d;
                            D_Done_out <= pick_d;
                            D_Err_out  <= pick_d;
                        end else begin
                            state              <= ST_ACCESS;
                            cnt                <= CNT_LOAD;
                            Mem_En_out         <= 1'b1;
                            Mem_Sel_RAM_out    <= ram_hit;
                            Mem_We_out         <= wr_sel;
                            Mem_Address_out    <= dec_idx;
                            Mem_Write_Data_out <= wr_sel ? D_Write_Data_in : '0;
                        end
                    end
                end

                ST_ACCESS: begin
                    if (cnt == '0) begin
                        state              <= ST_DONE;
                        Mem_En_out         <= 1'b0;
                        Mem_Sel_RAM_out    <= 1'b0;
                        Mem_We_out         <= 1'b0;
                        Mem_Address_out    <= '0;
                        Mem_Write_Data_out <= '0;
                        // Writes report zero read data.
                        if (gnt_d) begin
                            D_Done_out      <= 1'b1;
                            D_Read_Data_out <= Mem_We_out ? '0 : Mem_Read_Data_in;
                        end else begin
                            I_Done_out      <= 1'b1;
                            I_Read_Data_out <= Mem_Read_Data_in;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end

                ST_DONE: begin
                    state           <= ST_IDLE;
                    I_Done_out      <= 1'b0;
                    I_Err_out       <= 1'b0;
                    I_Read_Data_out <= '0;
                    D_Done_out      <= 1'b0;
                    D_Err_out       <= 1'b0;
                    D_Read_Data_out <= '0;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomized bench for mem_bus_arbiter: transaction-level reference model feeds a scoreboard queue.
module tb_mem_bus_arbiter;

    localparam int BW    = 32;
    localparam int ROM_D = 1024;
    localparam int RAM_D = 1024;
    localparam int LAT   = 3;
    localparam longint unsigned ROM_BASE = 64'h0040_0000;
    localparam longint unsigned RAM_BASE = 64'h1001_0000;

    logic          clk;
    logic          reset;
    logic          I_Req_in;
    logic [BW-1:0] I_Address_in;
    logic [BW-1:0] I_Read_Data_out;
    logic          I_Done_out;
    logic          I_Err_out;
    logic          D_Req_in;
    logic          D_Write_in;
    logic [BW-1:0] D_Address_in;
    logic [BW-1:0] D_Write_Data_in;
    logic [BW-1:0] D_Read_Data_out;
    logic          D_Done_out;
    logic          D_Err_out;
    logic          Mem_En_out;
    logic          Mem_Sel_RAM_out;
    logic          Mem_We_out;
    logic [BW-1:0] Mem_Address_out;
    logic [BW-1:0] Mem_Write_Data_out;
    logic [BW-1:0] Mem_Read_Data_in;

    mem_bus_arbiter #(
        .BIT_WIDTH(BW), .ROM_DEPTH(ROM_D), .RAM_DEPTH(RAM_D), .MEM_LATENCY(LAT)
    ) dut (
        .clk(clk), .reset(reset),
        .I_Req_in(I_Req_in), .I_Address_in(I_Address_in),
        .I_Read_Data_out(I_Read_Data_out), .I_Done_out(I_Done_out), .I_Err_out(I_Err_out),
        .D_Req_in(D_Req_in), .D_Write_in(D_Write_in), .D_Address_in(D_Address_in),
        .D_Write_Data_in(D_Write_Data_in), .D_Read_Data_out(D_Read_Data_out),
        .D_Done_out(D_Done_out), .D_Err_out(D_Err_out),
        .Mem_En_out(Mem_En_out), .Mem_Sel_RAM_out(Mem_Sel_RAM_out), .Mem_We_out(Mem_We_out),
        .Mem_Address_out(Mem_Address_out), .Mem_Write_Data_out(Mem_Write_Data_out),
        .Mem_Read_Data_in(Mem_Read_Data_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rom_val(int unsigned i);
        return (i == 2) ? 32'h2008_000A : (32'hA5A5_0000 ^ (32'(i) * 32'h0001_0003));
    endfunction

    function automatic logic [31:0] ram_init(int unsigned i);
        return 32'h5A00_0000 | 32'(i);
    endfunction

    // Memory arrays seen by the DUT
    logic [31:0]      ram_arr [RAM_D];
    logic [RAM_D-1:0] ram_vld;
    logic             mem_clr;
    logic [9:0]       mem_idx;

    assign mem_idx = Mem_Address_out[9:0];
    assign Mem_Read_Data_in = !Mem_En_out ? 32'h0 :
                              Mem_Sel_RAM_out ? (ram_vld[mem_idx] ? ram_arr[mem_idx] : ram_init(32'(mem_idx)))
                                              : rom_val(32'(mem_idx));

    always @(posedge clk) begin
        if (mem_clr) begin
            ram_vld <= '0;
        end else if (Mem_En_out && Mem_We_out && Mem_Sel_RAM_out) begin
            ram_arr[mem_idx] <= Mem_Write_Data_out;
            ram_vld[mem_idx] <= 1'b1;
        end
    end

    // Reference model state
    typedef struct {
        logic        port_d;
        logic        err;
        logic [31:0] data;
        int unsigned cyc;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] ref_ram [int unsigned];
    int unsigned cyc     = 0;
    int unsigned free_at = 0;
    logic        last_d  = 1'b1;
    int unsigned en_from = 1;
    int unsigned en_to   = 0;
    logic        en_sel  = 1'b0;
    logic [31:0] en_addr = 32'h0;
    logic        en_we   = 1'b0;
    logic [31:0] en_wd   = 32'h0;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s cycle %0d: got 0x%08h, expected 0x%08h", name, cyc, act, expv);
        end
    endtask

    // Transaction-level model: one transaction at a time, LAT+2 cycles for a hit, 2 for an error.
    always @(posedge clk) begin : model
        longint unsigned a;
        logic            pd, wr, in_rom, in_ram, err;
        int unsigned     idx;
        logic [31:0]     data;
        exp_t            e;
        if (reset) begin
            exp_q.delete();
            last_d  = 1'b1;
            free_at = cyc + 1;
            en_from = 1;
            en_to   = 0;
        end else if (cyc >= free_at && (I_Req_in || D_Req_in)) begin
            pd     = D_Req_in && (!I_Req_in || !last_d);
            last_d = pd;
            a      = pd ? 64'(D_Address_in) : 64'(I_Address_in);
            wr     = pd && D_Write_in;
            in_rom = (a >= ROM_BASE) && (a < ROM_BASE + 4 * ROM_D);
            in_ram = (a >= RAM_BASE) && (a < RAM_BASE + 4 * RAM_D);
            err    = (a % 4 != 0) || !(in_rom || in_ram) || (wr && in_rom) || (!pd && in_ram);
            e.port_d = pd;
            e.err    = err;
            if (err) begin
                e.data  = 32'h0;
                e.cyc   = cyc + 1;
                free_at = cyc + 2;
            end else begin
                idx = int'(in_rom ? (a - ROM_BASE) / 4 : (a - RAM_BASE) / 4);
                if (wr) data = 32'h0;
                else if (in_rom) data = rom_val(idx);
                else data = ref_ram.exists(idx) ? ref_ram[idx] : ram_init(idx);
                if (wr) ref_ram[idx] = D_Write_Data_in;
                e.data  = data;
                e.cyc   = cyc + LAT + 1;
                free_at = cyc + LAT + 2;
                en_from = cyc + 1;
                en_to   = cyc + LAT;
                en_sel  = in_ram;
                en_addr = 32'(idx);
                en_we   = wr;
                en_wd   = D_Write_Data_in;
            end
            exp_q.push_back(e);
        end
        cyc = cyc + 1;
    end

    // Scoreboard monitor, sampled mid-cycle
    always @(negedge clk) begin : monitor
        logic ei, ed, een;
        if (cyc > 0) begin
            ei = (exp_q.size() > 0) && (exp_q[0].cyc == cyc) && !exp_q[0].port_d;
            ed = (exp_q.size() > 0) && (exp_q[0].cyc == cyc) &&  exp_q[0].port_d;
            check("i_done", 32'(I_Done_out), 32'(ei));
            check("d_done", 32'(D_Done_out), 32'(ed));
            check("i_err",  32'(I_Err_out),  ei ? 32'(exp_q[0].err) : 32'h0);
            check("d_err",  32'(D_Err_out),  ed ? 32'(exp_q[0].err) : 32'h0);
            check("i_rdata", I_Read_Data_out, ei ? exp_q[0].data : 32'h0);
            check("d_rdata", D_Read_Data_out, ed ? exp_q[0].data : 32'h0);
            if (ei || ed) void'(exp_q.pop_front());
            een = (cyc >= en_from) && (cyc <= en_to);
            check("mem_en", 32'(Mem_En_out), 32'(een));
            if (een) begin
                check("mem_sel",  32'(Mem_Sel_RAM_out), 32'(en_sel));
                check("mem_addr", Mem_Address_out, en_addr);
                check("mem_we",   32'(Mem_We_out), 32'(en_we));
                if (en_we) check("mem_wdata", Mem_Write_Data_out, en_wd);
            end else begin
                check("mem_we_idle", 32'(Mem_We_out), 32'h0);
            end
        end
    end

    function automatic logic [31:0] gen_addr();
        logic [31:0] b [6];
        b[0] = 32'h0040_0000 + 32'(4 * ROM_D);
        b[1] = 32'h003F_FFFC;
        b[2] = 32'h1001_0000 + 32'(4 * RAM_D - 4);
        b[3] = 32'h1001_0000 + 32'(4 * RAM_D);
        b[4] = 32'h0040_0000 + 32'(4 * ROM_D - 4);
        b[5] = 32'h1001_0000;
        case ($urandom_range(0, 9))
            0, 1, 2: return 32'h0040_0000 + 32'(4 * $urandom_range(0, ROM_D - 1));
            3, 4:    return 32'h1001_0000 + 32'(4 * $urandom_range(0, 15));
            5:       return 32'h1001_0000 + 32'(4 * $urandom_range(0, RAM_D - 1));
            6:       return ($urandom_range(0, 1) ? 32'h1001_0000 : 32'h0040_0000)
                            + 32'(4 * $urandom_range(0, 255)) + 32'($urandom_range(1, 3));
            7:       return b[$urandom_range(0, 5)];
            8:       return $urandom();
            default: return 32'h0;
        endcase
    endfunction

    task automatic gen_i();
        if (I_Req_in) begin
            if (I_Done_out || $urandom_range(0, 15) == 0) I_Req_in = 1'b0;
            else if ($urandom_range(0, 3) == 0) I_Address_in = gen_addr();
        end else if ($urandom_range(0, 2) == 0) begin
            I_Req_in     = 1'b1;
            I_Address_in = gen_addr();
        end
    endtask

    task automatic gen_d();
        if (D_Req_in) begin
            if (D_Done_out || $urandom_range(0, 15) == 0) D_Req_in = 1'b0;
            else if ($urandom_range(0, 3) == 0) begin
                D_Address_in    = gen_addr();
                D_Write_Data_in = $urandom();
            end
        end else if ($urandom_range(0, 2) == 0) begin
            D_Req_in        = 1'b1;
            D_Write_in      = ($urandom_range(0, 2) == 0);
            D_Address_in    = gen_addr();
            D_Write_Data_in = $urandom();
        end
    endtask

    // Single request held until its Done, bounded by a cycle budget
    task automatic single(bit pd, bit wr, logic [31:0] addr, logic [31:0] wd);
        bit got = 1'b0;
        if (pd) begin
            D_Req_in = 1'b1; D_Write_in = wr; D_Address_in = addr; D_Write_Data_in = wd;
        end else begin
            I_Req_in = 1'b1; I_Address_in = addr;
        end
        for (int n = 0; n < 30 && !got; n++) begin
            @(posedge clk); #1;
            got = pd ? D_Done_out : I_Done_out;
        end
        check("done_seen", 32'(got), 32'h1);
        I_Req_in = 1'b0; D_Req_in = 1'b0; D_Write_in = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        reset = 1'b1; mem_clr = 1'b1;
        I_Req_in = 1'b0; I_Address_in = '0;
        D_Req_in = 1'b0; D_Write_in = 1'b0; D_Address_in = '0; D_Write_Data_in = '0;
        repeat (3) @(posedge clk);
        #1; reset = 1'b0; mem_clr = 1'b0;

        // Tie from reset with both held: expected order I, D, I, D
        I_Req_in = 1'b1; I_Address_in = 32'h0040_0008;
        D_Req_in = 1'b1; D_Write_in = 1'b1; D_Address_in = 32'h1001_0010; D_Write_Data_in = 32'hDEAD_BEEF;
        repeat (20) @(posedge clk);
        #1; I_Req_in = 1'b0; D_Req_in = 1'b0; D_Write_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        single(1'b1, 1'b0, 32'h1001_0010, 32'h0);
        single(1'b0, 1'b0, 32'h0040_0008, 32'h0);

        // Decode errors
        single(1'b1, 1'b0, 32'h1001_0002, 32'h0);
        single(1'b1, 1'b1, 32'h0040_0000, 32'h1234_5678);
        single(1'b0, 1'b0, 32'h1001_0000, 32'h0);
        single(1'b1, 1'b0, 32'h0000_0000, 32'h0);

        // Address change mid-access must not reach the memory port
        D_Req_in = 1'b1; D_Write_in = 1'b0; D_Address_in = 32'h1001_0000;
        @(posedge clk); #1;
        @(posedge clk); #1;
        D_Address_in = 32'h1001_0040;
        for (int n = 0; n < 10 && !D_Done_out; n++) begin
            @(posedge clk); #1;
        end
        D_Req_in = 1'b0;
        @(posedge clk); #1;

        // Reset in the second access cycle, then a tie
        D_Req_in = 1'b1; D_Address_in = 32'h1001_0000;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1; D_Req_in = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        I_Req_in = 1'b1; I_Address_in = 32'h0040_0004;
        D_Req_in = 1'b1; D_Address_in = 32'h1001_0004;
        repeat (5) @(posedge clk);
        #1; I_Req_in = 1'b0; D_Req_in = 1'b0;
        repeat (8) @(posedge clk);
        #1;

        // Randomized traffic with occasional resets
        for (int k = 0; k < 4000; k++) begin
            gen_i();
            gen_d();
            reset = ($urandom_range(0, 299) == 0);
            @(posedge clk); #1;
        end
        reset = 1'b0; I_Req_in = 1'b0; D_Req_in = 1'b0; D_Write_in = 1'b0;

        for (int n = 0; n < 50 && exp_q.size() != 0; n++) @(posedge clk);
        check("drain_pending", 32'(exp_q.size()), 32'h0);
        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
